// File: rtl/prbs7_xnor_checker.sv
// prbs7_xnor_checker: serial PRBS7 (XNOR feedback) receiver-side checker.
// Self-synchronises a local LFSR to din, declares lock, counts bit errors.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   din        received serial bit, sampled only when din_valid=1
//   din_valid  qualifies din; no backpressure
//   err_clr    synchronous clear of err_count (wins over a same-cycle error)
//   locked     registered, high while in LOCKED
//   bit_err    registered one-cycle pulse per mismatch seen in LOCKED
//   err_count  saturating count of mismatches seen in LOCKED
module prbs7_xnor_checker #(
   parameter int LOCK_CNT = 16,
   parameter int LOSS_CNT = 4,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             din,
   input  logic             din_valid,
   input  logic             err_clr,
   output logic             locked,
   output logic             bit_err,
   output logic [CNT_W-1:0] err_count
);

   localparam int MW = $clog2(LOCK_CNT + 1);
   localparam int LW = $clog2(LOSS_CNT + 1);
   localparam logic [MW-1:0]    MATCH_LAST = MW'(LOCK_CNT - 1);
   localparam logic [LW-1:0]    MISS_LAST  = LW'(LOSS_CNT - 1);
   localparam logic [MW-1:0]    MATCH_ONE  = MW'(1);
   localparam logic [LW-1:0]    MISS_ONE   = LW'(1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;

   typedef enum logic [1:0] {
      SEED   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [6:0]       s_q, s_d;
   logic [2:0]       seed_q, seed_d;
   logic [MW-1:0]    match_q, match_d;
   logic [LW-1:0]    miss_q, miss_d;
   logic [CNT_W-1:0] err_d;
   logic             bit_err_d;
   logic             pred;
   logic             mism;
   logic [6:0]       s_load;

   // s[6] is the oldest bit: b[n] = ~(b[n-7] ^ b[n-6])
   assign pred   = ~(s_q[6] ^ s_q[5]);
   assign mism   = din != pred;
   assign s_load = {s_q[5:0], din};

   always_comb begin
      state_d   = state_q;
      s_d       = s_q;
      seed_d    = seed_q;
      match_d   = match_q;
      miss_d    = miss_q;
      err_d     = err_count;
      bit_err_d = 1'b0;
      if (din_valid) begin
         unique case (state_q)
            SEED: begin
               s_d    = s_load;
               seed_d = seed_q + 3'd1;
               if (seed_q == 3'd6) begin
                  seed_d = '0;
                  // all-ones is the XNOR lock-up state: reseed
                  if (s_load != 7'h7f) begin
                     state_d = VERIFY;
                     match_d = '0;
                  end
               end
            end
            VERIFY: begin
               // reference free-runs; din is never loaded here
               s_d = {s_q[5:0], pred};
               if (mism) begin
                  state_d = SEED;
                  seed_d  = '0;
               end else if (match_q == MATCH_LAST) begin
                  state_d = LOCKED;
                  miss_d  = '0;
               end else begin
                  match_d = match_q + MATCH_ONE;
               end
            end
            LOCKED: begin
               s_d = {s_q[5:0], pred};
               if (mism) begin
                  bit_err_d = 1'b1;
                  if (err_count != CNT_MAX)
                     err_d = err_count + CNT_ONE;
                  if (miss_q == MISS_LAST) begin
                     state_d = SEED;
                     seed_d  = '0;
                  end else begin
                     miss_d = miss_q + MISS_ONE;
                  end
               end else begin
                  miss_d = '0;
               end
            end
            default: begin
               state_d = SEED;
               seed_d  = '0;
            end
         endcase
      end
      if (err_clr)
         err_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= SEED;
         s_q       <= '0;
         seed_q    <= '0;
         match_q   <= '0;
         miss_q    <= '0;
         locked    <= 1'b0;
         bit_err   <= 1'b0;
         err_count <= '0;
      end else begin
         state_q   <= state_d;
         s_q       <= s_d;
         seed_q    <= seed_d;
         match_q   <= match_d;
         miss_q    <= miss_d;
         locked    <= (state_d == LOCKED);
         bit_err   <= bit_err_d;
         err_count <= err_d;
      end
   end

endmodule
